// File: rtl/regs_scoreboard.sv
// rtl/regs_scoreboard.sv - hazard scoreboard and read-enable sequencer for the 8-entry register file
// Counts outstanding write-backs per register and holds issue while sources or destination are hazarded.
module regs_scoreboard #(
   parameter int MAX_PEND = 3,
   parameter int CNT_W    = 3
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        issue_valid_i,
   input  logic [2:0]  issue_src_1_i,
   input  logic [2:0]  issue_src_2_i,
   input  logic        issue_use_src_1_i,
   input  logic        issue_use_src_2_i,
   input  logic        issue_has_dest_i,
   input  logic [2:0]  issue_dest_i,
   output logic        issue_ready_o,
   output logic        regs_start_o,
   output logic        stall_o,
   input  logic        wb_valid_i,
   input  logic [2:0]  wb_dest_i,
   output logic [7:0]  busy_o,
   output logic        idle_o,
   output logic [15:0] stall_cnt_o,
   output logic        err_o
);

   localparam int REG_NR = 8;
   localparam logic [CNT_W-1:0] PEND_MAX = CNT_W'(MAX_PEND);

   logic [CNT_W-1:0] pend_q [REG_NR];
   logic [CNT_W-1:0] pend_d [REG_NR];
   logic [15:0]      stall_cnt_q, stall_cnt_d;
   logic             err_q, err_d;
   logic             raw_haz, ovf_haz, fire;

   // Hazards look only at registered counters, so a same-cycle write-back never unblocks.
   assign raw_haz = (issue_use_src_1_i && (pend_q[issue_src_1_i] != '0)) ||
                    (issue_use_src_2_i && (pend_q[issue_src_2_i] != '0));
   assign ovf_haz = issue_has_dest_i && (pend_q[issue_dest_i] == PEND_MAX);

   assign issue_ready_o = ~raw_haz & ~ovf_haz;
   assign fire          = issue_valid_i & issue_ready_o;
   assign regs_start_o  = fire;
   assign stall_o       = issue_valid_i & ~issue_ready_o;

   always_comb begin
      err_d       = err_q;
      stall_cnt_d = stall_cnt_q;
      if (stall_o && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
      for (int r = 0; r < REG_NR; r++) begin : g_cnt
         logic inc_r, wb_r, dec_r;
         inc_r     = fire && issue_has_dest_i && (issue_dest_i == 3'(r));
         wb_r      = wb_valid_i && (wb_dest_i == 3'(r));
         dec_r     = wb_r && (pend_q[r] != '0);
         pend_d[r] = pend_q[r];
         // A write-back with nothing outstanding is flagged and does not consume a later reservation.
         if (wb_r && (pend_q[r] == '0)) begin
            err_d = 1'b1;
         end
         if (inc_r && !dec_r) begin
            pend_d[r] = pend_q[r] + CNT_W'(1);
         end else if (!inc_r && dec_r) begin
            pend_d[r] = pend_q[r] - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         for (int r = 0; r < REG_NR; r++) begin
            pend_q[r] <= '0;
         end
         stall_cnt_q <= '0;
         err_q       <= 1'b0;
      end else begin
         for (int r = 0; r < REG_NR; r++) begin
            pend_q[r] <= pend_d[r];
         end
         stall_cnt_q <= stall_cnt_d;
         err_q       <= err_d;
      end
   end

   always_comb begin
      busy_o = '0;
      for (int r = 0; r < REG_NR; r++) begin
         busy_o[r] = (pend_q[r] != '0);
      end
   end

   assign idle_o      = ~|busy_o;
   assign stall_cnt_o = stall_cnt_q;
   assign err_o       = err_q;

endmodule
